// File: rtl/rename_register_file_pkg.sv
// Shared sizing constants and types for the rename register file.
// Latency: n/a (types only).  Backpressure: n/a.
// ROB_SIZE_BIT sets the ROB tag width (ROB depth = 2^ROB_SIZE_BIT).
// REG_NUM is the architectural register count.
package rename_register_file_pkg;

  localparam int ROB_SIZE_BIT = 3;
  localparam int ROB_SIZE     = 1 << ROB_SIZE_BIT;
  localparam int REG_NUM      = 32;
  localparam int REG_IDX_BIT  = 5;
  localparam int XLEN         = 32;

  typedef logic [REG_IDX_BIT-1:0]  reg_idx_t;
  typedef logic [XLEN-1:0]         word_t;
  typedef logic [ROB_SIZE_BIT-1:0] tag_t;

endpackage

// File: rtl/rename_register_file_if.sv
// Decoder/ROB-facing bus of the rename register file: flush, commit, rename
// and two source-operand query ports.
// Latency: n/a (wiring only).  Backpressure: none; rdy_in stalls are a top-level scalar.
// Ports: master = decoder/ROB side (drives commands and rs1/rs2);
//        slave  = register file side (returns val/has_dep/dep per port).
interface rename_register_file_if;
  import rename_register_file_pkg::*;

  logic     clear;
  reg_idx_t rob_set_idx;
  word_t    rob_set_reg_val;
  tag_t     rob_set_recorder;
  reg_idx_t dec_set_idx;
  tag_t     dec_set_dep;
  reg_idx_t rs1;
  word_t    val1;
  logic     has_dep1;
  tag_t     dep1;
  reg_idx_t rs2;
  word_t    val2;
  logic     has_dep2;
  tag_t     dep2;

  modport master (
    output clear, rob_set_idx, rob_set_reg_val, rob_set_recorder,
           dec_set_idx, dec_set_dep, rs1, rs2,
    input  val1, has_dep1, dep1, val2, has_dep2, dep2
  );

  modport slave (
    input  clear, rob_set_idx, rob_set_reg_val, rob_set_recorder,
           dec_set_idx, dec_set_dep, rs1, rs2,
    output val1, has_dep1, dep1, val2, has_dep2, dep2
  );

endinterface

// File: rtl/rename_register_file_rf_read_port.sv
// One source-operand read port: x0 masking, same-cycle commit forwarding, array lookup.
// Latency: combinational.  Backpressure: none.
// Ports: rs in; regs/busy/dep state arrays in; commit idx/val/tag in;
//        val/has_dep/dep_out out.
module rename_register_file_rf_read_port
  import rename_register_file_pkg::*;
(
  input  reg_idx_t                 rs,
  input  word_t [REG_NUM-1:0]      regs,
  input  logic  [REG_NUM-1:0]      busy,
  input  tag_t  [REG_NUM-1:0]      dep,
  input  reg_idx_t                 commit_idx,
  input  word_t                    commit_val,
  input  tag_t                     commit_tag,
  output word_t                    val,
  output logic                     has_dep,
  output tag_t                     dep_out
);

  always_comb begin
    val     = '0;
    has_dep = 1'b0;
    dep_out = '0;
    if (rs != '0) begin
      dep_out = dep[rs];
      // Forward only when this commit is the one the rename is waiting on;
      // a commit from an older, superseded producer must not clear the dependency.
      if ((commit_idx == rs) && busy[rs] && (dep[rs] == commit_tag)) begin
        val     = commit_val;
        has_dep = 1'b0;
      end else begin
        val     = regs[rs];
        has_dep = busy[rs];
      end
    end
  end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with per-register ROB rename tags (Tomasulo core).
// Latency: commit/rename/flush at next clk_in edge; queries combinational with commit forwarding.
// Backpressure: rdy_in low freezes all state; queries stay valid.
// Ports: clk_in, rst_in (async active-low), rdy_in, bus (slave modport: flush,
//        commit, rename, two query ports).
// Optional: define RF_TRACE_EN for a commit counter and a per-commit trace print.
module rename_register_file
  import rename_register_file_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  rename_register_file_if.slave  bus
);

  word_t [REG_NUM-1:0] regs;
  logic  [REG_NUM-1:0] busy;
  tag_t  [REG_NUM-1:0] dep;

  logic commit_en;
  logic rename_en;

  assign commit_en = rdy_in && !bus.clear && (bus.rob_set_idx != '0);
  assign rename_en = rdy_in && !bus.clear && (bus.dec_set_idx != '0);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      regs <= '0;
      busy <= '0;
      dep  <= '0;
    end else if (rdy_in) begin
      if (bus.clear) begin
        // Flush drops pending renames only; committed values survive.
        busy <= '0;
      end else begin
        if (commit_en) begin
          regs[bus.rob_set_idx] <= bus.rob_set_reg_val;
          if (busy[bus.rob_set_idx] && (dep[bus.rob_set_idx] == bus.rob_set_recorder)) begin
            busy[bus.rob_set_idx] <= 1'b0;
          end
        end
        // Issued after the commit so a same-register rename wins busy/dep.
        if (rename_en) begin
          busy[bus.dec_set_idx] <= 1'b1;
          dep[bus.dec_set_idx]  <= bus.dec_set_dep;
        end
      end
    end
  end

  rename_register_file_rf_read_port u_port1 (
    .rs         (bus.rs1),
    .regs       (regs),
    .busy       (busy),
    .dep        (dep),
    .commit_idx (bus.rob_set_idx),
    .commit_val (bus.rob_set_reg_val),
    .commit_tag (bus.rob_set_recorder),
    .val        (bus.val1),
    .has_dep    (bus.has_dep1),
    .dep_out    (bus.dep1)
  );

  rename_register_file_rf_read_port u_port2 (
    .rs         (bus.rs2),
    .regs       (regs),
    .busy       (busy),
    .dep        (dep),
    .commit_idx (bus.rob_set_idx),
    .commit_val (bus.rob_set_reg_val),
    .commit_tag (bus.rob_set_recorder),
    .val        (bus.val2),
    .has_dep    (bus.has_dep2),
    .dep_out    (bus.dep2)
  );

`ifdef RF_TRACE_EN
  logic [31:0] commit_cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      commit_cnt <= '0;
    end else if (commit_en) begin
      commit_cnt <= commit_cnt + 32'd1;
      $display("rf commit #%0d x%0d <= %h", commit_cnt, bus.rob_set_idx, bus.rob_set_reg_val);
    end
  end
`else
`endif

endmodule

// File: tb/tb_rename_register_file.sv
// Self-checking bench for rename_register_file: directed scenarios plus a
// randomized run compared against an array-based reference model.
module tb_rename_register_file;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;

  rename_register_file_if rf_if ();

  rename_register_file dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (rf_if)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          m_dep  [32];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
      m_dep[i]  = 0;
    end
  endfunction

  // Apply one clock's worth of the architectural rules to the model.
  function automatic void model_clock();
    int ci, di;
    ci = int'(rf_if.rob_set_idx);
    di = int'(rf_if.dec_set_idx);
    if (!rdy_in) return;
    if (rf_if.clear) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      return;
    end
    if (ci != 0) begin
      m_regs[ci] = rf_if.rob_set_reg_val;
      if (m_busy[ci] && m_dep[ci] == int'(rf_if.rob_set_recorder)) m_busy[ci] = 1'b0;
    end
    if (di != 0) begin
      m_busy[di] = 1'b1;
      m_dep[di]  = int'(rf_if.dec_set_dep);
    end
  endfunction

  // Expected query result; dchk says whether the dep output is defined.
  function automatic void exp_query(input int rs, output logic [31:0] v, output logic h,
                                    output logic [2:0] d, output bit dchk);
    v = 32'd0; h = 1'b0; d = 3'd0; dchk = 1'b1;
    if (rs == 0) return;
    if (int'(rf_if.rob_set_idx) == rs && m_busy[rs] && m_dep[rs] == int'(rf_if.rob_set_recorder)) begin
      v = rf_if.rob_set_reg_val; h = 1'b0; dchk = 1'b0;
    end else begin
      v = m_regs[rs]; h = m_busy[rs]; d = 3'(m_dep[rs]);
    end
  endfunction

  task automatic idle();
    rdy_in                 = 1'b1;
    rf_if.clear            = 1'b0;
    rf_if.rob_set_idx      = 5'd0;
    rf_if.rob_set_reg_val  = 32'd0;
    rf_if.rob_set_recorder = 3'd0;
    rf_if.dec_set_idx      = 5'd0;
    rf_if.dec_set_dep      = 3'd0;
    rf_if.rs1              = 5'd0;
    rf_if.rs2              = 5'd0;
  endtask

  // Clock edge: model advances with the inputs held across the edge, then
  // returns at the falling edge ready for new stimulus.
  task automatic tick();
    @(posedge clk_in);
    model_clock();
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    idle();
    model_reset();
    rf_if.rs1 = 5'd5;
    rf_if.rs2 = 5'd0;
    #2;
    vectors++;
    if (rf_if.val1 !== 32'd0 || rf_if.has_dep1 !== 1'b0 || rf_if.dep1 !== 3'd0) begin
      errors++;
      $display("FAIL reset_port1 got val=%h has=%b dep=%0d exp 0/0/0", rf_if.val1, rf_if.has_dep1, rf_if.dep1);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    vectors++;
    if (rf_if.val1 !== 32'd0 || rf_if.has_dep1 !== 1'b0 || rf_if.val2 !== 32'd0 || rf_if.has_dep2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got v1=%h h1=%b v2=%h h2=%b exp 0", rf_if.val1, rf_if.has_dep1, rf_if.val2, rf_if.has_dep2);
    end
    @(negedge clk_in);
  endtask

  task automatic test_rename_commit();
    idle();
    rf_if.dec_set_idx = 5'd3; rf_if.dec_set_dep = 3'd2;
    rf_if.rs1 = 5'd3;
    #1;
    vectors++;
    if (rf_if.has_dep1 !== 1'b0) begin
      errors++;
      $display("FAIL rename_not_visible got has=%b exp 0", rf_if.has_dep1);
    end
    tick();
    idle();
    rf_if.rs1 = 5'd3;
    #1;
    vectors++;
    if (rf_if.has_dep1 !== 1'b1 || rf_if.dep1 !== 3'd2) begin
      errors++;
      $display("FAIL rename_dep got has=%b dep=%0d exp has=1 dep=2", rf_if.has_dep1, rf_if.dep1);
    end
    rf_if.rob_set_idx = 5'd3; rf_if.rob_set_reg_val = 32'hDEAD; rf_if.rob_set_recorder = 3'd2;
    rf_if.rs2 = 5'd3;
    #1;
    vectors++;
    if (rf_if.val2 !== 32'hDEAD || rf_if.has_dep2 !== 1'b0) begin
      errors++;
      $display("FAIL commit_forward got val=%h has=%b exp val=0000dead has=0", rf_if.val2, rf_if.has_dep2);
    end
    tick();
    idle();
    rf_if.rs1 = 5'd3;
    #1;
    vectors++;
    if (rf_if.val1 !== 32'hDEAD || rf_if.has_dep1 !== 1'b0) begin
      errors++;
      $display("FAIL commit_state got val=%h has=%b exp val=0000dead has=0", rf_if.val1, rf_if.has_dep1);
    end
  endtask

  task automatic test_stale_commit();
    idle();
    rf_if.dec_set_idx = 5'd4; rf_if.dec_set_dep = 3'd1;
    tick();
    idle();
    rf_if.dec_set_idx = 5'd4; rf_if.dec_set_dep = 3'd5;
    tick();
    idle();
    rf_if.rob_set_idx = 5'd4; rf_if.rob_set_reg_val = 32'd7; rf_if.rob_set_recorder = 3'd1;
    rf_if.rs1 = 5'd4;
    #1;
    vectors++;
    if (rf_if.val1 !== 32'd0 || rf_if.has_dep1 !== 1'b1 || rf_if.dep1 !== 3'd5) begin
      errors++;
      $display("FAIL stale_no_forward got val=%h has=%b dep=%0d exp 0/1/5", rf_if.val1, rf_if.has_dep1, rf_if.dep1);
    end
    tick();
    idle();
    rf_if.rs1 = 5'd4;
    #1;
    vectors++;
    if (rf_if.val1 !== 32'd7 || rf_if.has_dep1 !== 1'b1 || rf_if.dep1 !== 3'd5) begin
      errors++;
      $display("FAIL stale_state got val=%h has=%b dep=%0d exp 7/1/5", rf_if.val1, rf_if.has_dep1, rf_if.dep1);
    end
  endtask

  task automatic test_same_cycle();
    idle();
    rf_if.dec_set_idx = 5'd6; rf_if.dec_set_dep = 3'd0;
    tick();
    idle();
    rf_if.dec_set_idx = 5'd6; rf_if.dec_set_dep = 3'd3;
    rf_if.rob_set_idx = 5'd6; rf_if.rob_set_reg_val = 32'd9; rf_if.rob_set_recorder = 3'd0;
    rf_if.rs1 = 5'd6;
    #1;
    vectors++;
    if (rf_if.val1 !== 32'd9 || rf_if.has_dep1 !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_query got val=%h has=%b exp 9/0", rf_if.val1, rf_if.has_dep1);
    end
    tick();
    idle();
    rf_if.rs1 = 5'd6;
    #1;
    vectors++;
    if (rf_if.val1 !== 32'd9 || rf_if.has_dep1 !== 1'b1 || rf_if.dep1 !== 3'd3) begin
      errors++;
      $display("FAIL same_cycle_state got val=%h has=%b dep=%0d exp 9/1/3", rf_if.val1, rf_if.has_dep1, rf_if.dep1);
    end
  endtask

  task automatic test_flush();
    idle();
    rf_if.dec_set_idx = 5'd1; rf_if.dec_set_dep = 3'd1;
    tick();
    rf_if.dec_set_idx = 5'd2; rf_if.dec_set_dep = 3'd2;
    tick();
    rf_if.dec_set_idx = 5'd7; rf_if.dec_set_dep = 3'd3;
    tick();
    idle();
    rf_if.clear = 1'b1;
    rf_if.rob_set_idx = 5'd1; rf_if.rob_set_reg_val = 32'h11; rf_if.rob_set_recorder = 3'd1;
    rf_if.dec_set_idx = 5'd8; rf_if.dec_set_dep = 3'd4;
    tick();
    idle();
    rf_if.rs1 = 5'd1; rf_if.rs2 = 5'd8;
    #1;
    vectors++;
    if (rf_if.val1 !== 32'd0 || rf_if.has_dep1 !== 1'b0) begin
      errors++;
      $display("FAIL flush_x1 got val=%h has=%b exp 0/0", rf_if.val1, rf_if.has_dep1);
    end
    vectors++;
    if (rf_if.has_dep2 !== 1'b0) begin
      errors++;
      $display("FAIL flush_x8 got has=%b exp 0", rf_if.has_dep2);
    end
    rf_if.rs1 = 5'd2; rf_if.rs2 = 5'd7;
    #1;
    vectors++;
    if (rf_if.has_dep1 !== 1'b0 || rf_if.has_dep2 !== 1'b0) begin
      errors++;
      $display("FAIL flush_x2_x7 got has1=%b has2=%b exp 0/0", rf_if.has_dep1, rf_if.has_dep2);
    end
  endtask

  task automatic test_rdy_hold();
    idle();
    rf_if.dec_set_idx = 5'd9; rf_if.dec_set_dep = 3'd2;
    tick();
    idle();
    rdy_in = 1'b0;
    rf_if.rob_set_idx = 5'd9; rf_if.rob_set_reg_val = 32'h99; rf_if.rob_set_recorder = 3'd2;
    rf_if.dec_set_idx = 5'd10; rf_if.dec_set_dep = 3'd6;
    rf_if.rs1 = 5'd9;
    #1;
    vectors++;
    if (rf_if.val1 !== 32'h99 || rf_if.has_dep1 !== 1'b0) begin
      errors++;
      $display("FAIL stall_forward got val=%h has=%b exp 99/0", rf_if.val1, rf_if.has_dep1);
    end
    tick();
    idle();
    rf_if.rs1 = 5'd9; rf_if.rs2 = 5'd10;
    #1;
    vectors++;
    if (rf_if.val1 !== 32'd0 || rf_if.has_dep1 !== 1'b1 || rf_if.dep1 !== 3'd2) begin
      errors++;
      $display("FAIL stall_hold_x9 got val=%h has=%b dep=%0d exp 0/1/2", rf_if.val1, rf_if.has_dep1, rf_if.dep1);
    end
    vectors++;
    if (rf_if.has_dep2 !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold_x10 got has=%b exp 0", rf_if.has_dep2);
    end
  endtask

  task automatic test_x0();
    idle();
    rf_if.rob_set_idx = 5'd0; rf_if.rob_set_reg_val = 32'hFFFF_FFFF; rf_if.rob_set_recorder = 3'd0;
    rf_if.dec_set_idx = 5'd0; rf_if.dec_set_dep = 3'd7;
    tick();
    idle();
    rf_if.rs1 = 5'd0; rf_if.rs2 = 5'd0;
    #1;
    vectors++;
    if (rf_if.val1 !== 32'd0 || rf_if.has_dep1 !== 1'b0 || rf_if.dep1 !== 3'd0 ||
        rf_if.val2 !== 32'd0 || rf_if.has_dep2 !== 1'b0 || rf_if.dep2 !== 3'd0) begin
      errors++;
      $display("FAIL x0_read got v1=%h h1=%b d1=%0d v2=%h h2=%b d2=%0d exp all 0",
               rf_if.val1, rf_if.has_dep1, rf_if.dep1, rf_if.val2, rf_if.has_dep2, rf_if.dep2);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    rf_if.dec_set_idx = 5'd5; rf_if.dec_set_dep = 3'd3;
    tick();
    idle();
    rf_if.rs1 = 5'd5; rf_if.rs2 = 5'd3;
    #2;
    rst_in = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (rf_if.has_dep1 !== 1'b0 || rf_if.dep1 !== 3'd0 || rf_if.val2 !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset got h1=%b d1=%0d v2=%h exp 0/0/0", rf_if.has_dep1, rf_if.dep1, rf_if.val2);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_random();
    logic [31:0] ev;
    logic        eh;
    logic [2:0]  ed;
    bit          edc;
    int          ci;
    for (int n = 0; n < 400; n++) begin
      idle();
      rdy_in      = ($urandom_range(0, 7) != 0);
      rf_if.clear = ($urandom_range(0, 19) == 0);
      ci = int'($urandom_range(0, 7));
      rf_if.rob_set_idx     = 5'(ci);
      rf_if.rob_set_reg_val = $urandom;
      rf_if.rob_set_recorder = ($urandom_range(0, 1) != 0) ? 3'(m_dep[ci]) : 3'($urandom_range(0, 7));
      rf_if.dec_set_idx = 5'($urandom_range(0, 7));
      rf_if.dec_set_dep = 3'($urandom_range(0, 7));
      rf_if.rs1 = ($urandom_range(0, 1) != 0) ? 5'(ci) : 5'($urandom_range(0, 7));
      rf_if.rs2 = 5'($urandom_range(0, 31));
      #1;
      exp_query(int'(rf_if.rs1), ev, eh, ed, edc);
      vectors++;
      if (rf_if.val1 !== ev || rf_if.has_dep1 !== eh || (edc && rf_if.dep1 !== ed)) begin
        errors++;
        $display("FAIL rand_port1 n=%0d rs=%0d got %h/%b/%0d exp %h/%b/%0d",
                 n, rf_if.rs1, rf_if.val1, rf_if.has_dep1, rf_if.dep1, ev, eh, ed);
      end
      exp_query(int'(rf_if.rs2), ev, eh, ed, edc);
      vectors++;
      if (rf_if.val2 !== ev || rf_if.has_dep2 !== eh || (edc && rf_if.dep2 !== ed)) begin
        errors++;
        $display("FAIL rand_port2 n=%0d rs=%0d got %h/%b/%0d exp %h/%b/%0d",
                 n, rf_if.rs2, rf_if.val2, rf_if.has_dep2, rf_if.dep2, ev, eh, ed);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_same_cycle();
    test_flush();
    test_rdy_hold();
    test_x0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rename_register_file.md
# rename_register_file

Architectural register file with per-register rename tags for the Tomasulo core. Sits between the decoder (issue) and the reorder buffer (commit). The decoder queries source operands and records the producing ROB index of each destination. The ROB commits results here, and a flush drops every pending rename.

## Interface
- `ROB_SIZE_BIT`, 3: width of a ROB index (ROB depth = 2^ROB_SIZE_BIT).
- `clk_in` in 1: system clock.
- `rst_in` in 1: asynchronous, active-low reset.
- `rdy_in` in 1: when low, no state changes.
- `clear` in 1: ROB flush after a branch mispredict.
- `rob_set_idx` in 5: commit destination; 0 = no commit.
- `rob_set_reg_val` in 32: commit value.
- `rob_set_recorder` in ROB_SIZE_BIT: ROB index being committed.
- `dec_set_idx` in 5: rename destination; 0 = no rename.
- `dec_set_dep` in ROB_SIZE_BIT: ROB tail index allocated to the issuing instruction.
- `rs1` in 5: source 1 register number.
- `val1` out 32: source 1 value.
- `has_dep1` out 1: source 1 is pending.
- `dep1` out ROB_SIZE_BIT: source 1 ROB tag.
- `rs2`, `val2`, `has_dep2`, `dep2`: same as source 1, for source 2.

## Operation
- State: `regs[0:31]` (32b each), `busy[0:31]`, `dep[0:31]`.
- x0 is hardwired:
  - reads return value 0 and no dependency;
  - commits and renames to index 0 are ignored.
- Priority per clock, only while `rdy_in` is high: flush, then rename, then commit.
- Flush (`clear`=1):
  - all busy[]=0;
  - the same-cycle commit and rename are discarded;
  - regs[] are unchanged.
- Commit (`rob_set_idx`≠0):
  - regs[idx] <= rob_set_reg_val, unconditionally;
  - busy[idx] <= 0 only if busy[idx] is set and dep[idx]==rob_set_recorder (a younger rename owns the register otherwise).
- Rename (`dec_set_idx`≠0): busy[idx] <= 1 and dep[idx] <= dec_set_dep.
- Rename and commit on the same register in the same cycle: the rename wins for busy/dep; regs[] still takes the commit value.
- Query (combinational, per port):
  - If rs==0: val=0, has_dep=0, dep=0.
  - Else if the same-cycle commit targets rs and busy[rs] is set with dep[rs]==recorder (forwarding): val=rob_set_reg_val, has_dep=0.
  - Else: val=regs[rs], has_dep=busy[rs], dep=dep[rs].
  - A same-cycle rename is never visible to the query. An instruction reads its sources before its own rd rename, so `addi x1,x1,1` sees the old x1.
- `rdy_in` low: registers hold; queries remain combinationally valid.

## Timing
- Reset asserted: asynchronous clear of all regs/busy/dep to 0. Outputs follow immediately: val=0, has_dep=0, dep=0 on both ports.
- Reset mid-operation drops all pending renames.
- Commit/rename take effect at the next rising edge. Query outputs are zero-latency, with commit forwarding in the same cycle.
- ROB tag wrap-around: the dep compare is an exact ROB_SIZE_BIT match. A stale commit from an older instance of the same tag cannot occur, because the ROB never reissues a tag before committing it.

## Configuration
- `RF_TRACE_EN` defined:
  - a 32-bit commit counter increments on every accepted commit;
  - a `$display` prints counter, register, and value per write.
- `RF_TRACE_EN` undefined: no counter, no display; functionality is identical.

## Structure
- Shared `config.v` macros: `ROB_SIZE_BIT`, `ROB_SIZE`, `REG_NUM` (32).
- One natural sub-module, `rf_read_port`: the x0/forwarding/lookup mux, instantiated twice (rs1, rs2).
- The state arrays stay in the top.

## Test plan
- Reset low, then release; query rs1=5, rs2=0 → val=0, has_dep=0 on both ports.
- Rename x3→tag 2; next cycle query x3 → has_dep=1, dep=2. Commit idx=3, val=0xDEAD, recorder=2 → same-cycle query gives val=0xDEAD, has_dep=0; next cycle the registered state matches.
- Stale commit:
  - stimulus: rename x4→1, then rename x4→5, then commit x4 with recorder=1 and val=7;
  - response: regs[4]=7, busy[4]=1, dep=5.
- Same-cycle rename x6→3 with commit x6, recorder=old tag 0 (busy, dep=0), val=9:
  - regs[6]=9, busy=1, dep=3;
  - the query that cycle shows value 9 with no dependency.
- Flush:
  - stimulus: rename x1, x2, x7; then pulse clear together with a commit x1=0x11 and a rename x8;
  - response: all has_dep=0, regs[1] unchanged, x8 not busy.
- Hold `rdy_in`=0 during a commit to x9 and a rename of x10 → no state change. Writes to x0 → queries of x0 remain 0 with no dependency.
